// File: rtl/fetch_unit.sv
// IF stage with IF/ID pipeline register: PC, single-outstanding fetch FSM,
// one-entry skid buffer for responses decode cannot take, stall/flush/redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        StallD_i,
    input  logic        FlushD_i,
    input  logic        PCSrcE_i,
    input  logic [31:0] PCTargetE_i,
    output logic [31:0] InstrD_o,
    output logic [31:0] PCD_o,
    output logic [31:0] PCPlus4D_o,
    output logic        ValidD_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;

    logic        req_valid_s;
    logic        hs_s;
    logic        live_rsp_s;
    logic        ifid_load_s;

    // Request gating, handshake and IF/ID load qualifiers
    always_comb begin
        req_valid_s = 1'b0;
        if (!rst_i && !PCSrcE_i && !skid_v_q) begin
            if (state_q == S_REQ) begin
                req_valid_s = 1'b1;
            end else if (state_q == S_WAIT) begin
                req_valid_s = imem_rsp_valid_i & ~(valid_q & StallD_i);
            end else begin
                req_valid_s = 1'b0;
            end
        end else begin
            req_valid_s = 1'b0;
        end
        hs_s        = req_valid_s & imem_req_ready_i;
        live_rsp_s  = (state_q == S_WAIT) & imem_rsp_valid_i & ~PCSrcE_i;
        ifid_load_s = ~(FlushD_i | PCSrcE_i) & ~(StallD_i & valid_q);
    end

    // Fetch FSM next state, PC and outstanding-request PC
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            S_REQ: begin
                if (hs_s) state_d = S_WAIT;
                else      state_d = S_REQ;
            end
            S_WAIT: begin
                if (PCSrcE_i) begin
                    if (imem_rsp_valid_i) state_d = S_REQ;
                    else                  state_d = S_KILL;
                end else if (hs_s) begin
                    state_d = S_WAIT;
                end else if (imem_rsp_valid_i) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_KILL: begin
                // the stale response retires the only outstanding request
                if (imem_rsp_valid_i) state_d = S_REQ;
                else                  state_d = S_KILL;
            end
            default: state_d = S_REQ;
        endcase
        if (PCSrcE_i) begin
            pc_d = PCTargetE_i & 32'hFFFF_FFFC;
        end else if (hs_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
        if (hs_s) begin
            req_pc_d = pc_q;
        end else begin
            req_pc_d = req_pc_q;
        end
    end

    // IF/ID register and skid buffer next state
    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (FlushD_i || PCSrcE_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (StallD_i && valid_q) begin
            valid_d = valid_q;
        end else if (skid_v_q) begin
            valid_d = 1'b1;
            instr_d = skid_instr_q;
            pcd_d   = skid_pc_q;
        end else if (live_rsp_s) begin
            valid_d = 1'b1;
            instr_d = imem_rsp_data_i;
            pcd_d   = req_pc_q;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
        // a live response the IF/ID register does not take is parked in the skid
        if (PCSrcE_i) begin
            skid_v_d = 1'b0;
        end else if (live_rsp_s && !(ifid_load_s && !skid_v_q)) begin
            skid_v_d     = 1'b1;
            skid_instr_d = imem_rsp_data_i;
            skid_pc_d    = req_pc_q;
        end else if (ifid_load_s && skid_v_q) begin
            skid_v_d = 1'b0;
        end else begin
            skid_v_d = skid_v_q;
        end
    end

    // Fetch FSM, PC and request PC registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Skid buffer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_v_q     <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0000_0000;
        end else begin
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
        end
    end

    assign imem_req_valid_o = req_valid_s;
    assign imem_req_addr_o  = pc_q;
    assign ValidD_o         = valid_q;
    assign InstrD_o         = instr_q;
    assign PCD_o            = pcd_q;
    assign PCPlus4D_o       = pcd_q + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall/skid, redirect, flush+stall,
// async reset mid-request and request backpressure, against a latency-configurable imem.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0000_0000;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pctarget_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          mem_lat  = 1;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr = 32'h0000_0000;
    int          pend_cnt = 0;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .StallD_i         (stall_d),
        .FlushD_i         (flush_d),
        .PCSrcE_i         (pcsrc_e),
        .PCTargetE_i      (pctarget_e),
        .InstrD_o         (instr_d),
        .PCD_o            (pc_d),
        .PCPlus4D_o       (pcplus4_d),
        .ValidD_o         (valid_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hBEEF, a[15:0]};
    endfunction

    // Instruction memory: accepts at the negedge sample, answers mem_lat cycles later
    always begin : imem_model
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_cnt  = mem_lat - 1;
        end
        @(posedge clk);
        #1;
        if (pend && pend_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend) pend_cnt = pend_cnt - 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
        pcsrc_e = 1'b0; pctarget_e = 32'h0000_0000;
        #2;
        check_val("rst_valid",  {31'd0, valid_d}, 32'd0);
        check_val("rst_instr",  instr_d, NOP);
        check_val("rst_pcd",    pc_d, 32'h0000_0000);
        check_val("rst_pcp4",   pcplus4_d, 32'h0000_0004);
        check_val("rst_reqv",   {31'd0, imem_req_valid}, 32'd0);

        @(posedge clk); #1; rst = 1'b0;
        mid;
        check_val("t1_reqv0",   {31'd0, imem_req_valid}, 32'd1);
        check_val("t1_addr0",   imem_req_addr, 32'h0000_0100);
        tick; mid;
        check_val("t1_addr1",   imem_req_addr, 32'h0000_0104);
        check_val("t1_valid1",  {31'd0, valid_d}, 32'd0);
        tick; mid;
        check_val("t1_valid2",  {31'd0, valid_d}, 32'd1);
        check_val("t1_pcd2",    pc_d, 32'h0000_0100);
        check_val("t1_instr2",  instr_d, mem_word(32'h0000_0100));
        check_val("t1_pcp4",    pcplus4_d, 32'h0000_0104);
        check_val("t1_addr2",   imem_req_addr, 32'h0000_0108);

        tick; stall_d = 1'b1; mid;
        check_val("t2_pcd3",    pc_d, 32'h0000_0104);
        check_val("t2_reqv3",   {31'd0, imem_req_valid}, 32'd0);
        tick; mid;
        check_val("t2_pcd4",    pc_d, 32'h0000_0104);
        check_val("t2_reqv4",   {31'd0, imem_req_valid}, 32'd0);
        tick; mid;
        check_val("t2_pcd5",    pc_d, 32'h0000_0104);
        check_val("t2_reqv5",   {31'd0, imem_req_valid}, 32'd0);
        tick; stall_d = 1'b0; mid;
        check_val("t2_skid_reqv", {31'd0, imem_req_valid}, 32'd0);
        check_val("t2_pcd6",    pc_d, 32'h0000_0104);
        tick; mid;
        check_val("t2_pcd7",    pc_d, 32'h0000_0108);
        check_val("t2_instr7",  instr_d, mem_word(32'h0000_0108));
        check_val("t2_reqv7",   {31'd0, imem_req_valid}, 32'd1);
        check_val("t2_addr7",   imem_req_addr, 32'h0000_010C);
        tick; mid;
        check_val("t2_valid8",  {31'd0, valid_d}, 32'd0);
        check_val("t2_addr8",   imem_req_addr, 32'h0000_0110);
        tick; mem_lat = 2; mid;
        check_val("t2_pcd9",    pc_d, 32'h0000_010C);
        check_val("t2_addr9",   imem_req_addr, 32'h0000_0114);

        tick; pcsrc_e = 1'b1; pctarget_e = 32'h0000_0203; mid;
        check_val("t3_pcd10",   pc_d, 32'h0000_0110);
        check_val("t3_reqv10",  {31'd0, imem_req_valid}, 32'd0);
        tick; pcsrc_e = 1'b0; pctarget_e = 32'h0000_0000; mem_lat = 1; mid;
        check_val("t3_valid11", {31'd0, valid_d}, 32'd0);
        check_val("t3_instr11", instr_d, NOP);
        check_val("t3_pcd11",   pc_d, 32'h0000_0110);
        check_val("t3_reqv11",  {31'd0, imem_req_valid}, 32'd0);
        tick; mid;
        check_val("t3_reqv12",  {31'd0, imem_req_valid}, 32'd1);
        check_val("t3_addr12",  imem_req_addr, 32'h0000_0200);
        check_val("t3_valid12", {31'd0, valid_d}, 32'd0);
        tick; mid;
        check_val("t3_valid13", {31'd0, valid_d}, 32'd0);
        check_val("t3_addr13",  imem_req_addr, 32'h0000_0204);

        tick; flush_d = 1'b1; stall_d = 1'b1; mid;
        check_val("t3_pcd14",   pc_d, 32'h0000_0200);
        check_val("t3_instr14", instr_d, mem_word(32'h0000_0200));
        check_val("t5_valid14", {31'd0, valid_d}, 32'd1);
        check_val("t5_reqv14",  {31'd0, imem_req_valid}, 32'd0);
        tick; flush_d = 1'b0; stall_d = 1'b0; mid;
        check_val("t5_valid15", {31'd0, valid_d}, 32'd0);
        check_val("t5_instr15", instr_d, NOP);
        check_val("t5_reqv15",  {31'd0, imem_req_valid}, 32'd0);
        tick; mid;
        check_val("t5_valid16", {31'd0, valid_d}, 32'd1);
        check_val("t5_pcd16",   pc_d, 32'h0000_0204);
        check_val("t5_instr16", instr_d, mem_word(32'h0000_0204));
        check_val("t5_addr16",  imem_req_addr, 32'h0000_0208);

        tick; rst = 1'b1; #1;
        check_val("t6_valid",   {31'd0, valid_d}, 32'd0);
        check_val("t6_instr",   instr_d, NOP);
        check_val("t6_pcd",     pc_d, 32'h0000_0000);
        check_val("t6_pcp4",    pcplus4_d, 32'h0000_0004);
        check_val("t6_reqv",    {31'd0, imem_req_valid}, 32'd0);
        #1; rst = 1'b0;
        mid;
        check_val("t6_reqv17",  {31'd0, imem_req_valid}, 32'd1);
        check_val("t6_addr17",  imem_req_addr, RST_PC);

        tick; imem_req_ready = 1'b0; mid;
        check_val("t4_reqv18",  {31'd0, imem_req_valid}, 32'd1);
        check_val("t4_addr18",  imem_req_addr, 32'h0000_0104);
        tick; mid;
        check_val("t4_pcd19",   pc_d, 32'h0000_0100);
        check_val("t4_reqv19",  {31'd0, imem_req_valid}, 32'd1);
        check_val("t4_addr19",  imem_req_addr, 32'h0000_0104);
        tick; mid;
        check_val("t4_addr20",  imem_req_addr, 32'h0000_0104);
        tick; mid;
        check_val("t4_reqv21",  {31'd0, imem_req_valid}, 32'd1);
        check_val("t4_addr21",  imem_req_addr, 32'h0000_0104);
        tick; imem_req_ready = 1'b1; mid;
        check_val("t4_addr22",  imem_req_addr, 32'h0000_0104);
        tick; mid;
        check_val("t4_addr23",  imem_req_addr, 32'h0000_0108);
        tick; mid;
        check_val("t4_pcd24",   pc_d, 32'h0000_0104);
        check_val("t4_instr24", instr_d, mem_word(32'h0000_0104));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
